// File: rtl/io_channels.sv
// io_channels: responder side of the Core I/O channel bus.
// Holds the output channel registers, returns channel contents on the
// combinational read port, synchronizes external discretes and the DSKY
// keyboard, and queues DSKY display words in a small valid/ready FIFO.
module io_channels #(
   parameter int FIFO_DEPTH  = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic [4:0]  IO_read_sel,
   output logic [14:0] IO_read_data,
   input  logic [4:0]  IO_write_sel,
   input  logic [14:0] IO_write_data,
   input  logic        IO_write_en_F,
   input  logic [59:0] ext_in,
   input  logic [4:0]  key_code,
   input  logic        key_strobe,
   output logic [14:0] out_ch11,
   output logic [14:0] out_ch12,
   output logic [14:0] out_ch13,
   output logic [14:0] out_ch14,
   output logic [14:0] dsky_data,
   output logic        dsky_valid,
   input  logic        dsky_ready
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   // All asynchronous inputs travel together: {strobe, keycode, discretes}
   logic [SYNC_STAGES-1:0][65:0] async_sync;
   logic [65:0]                  sync_last;
   logic [59:0]                  ext_sync;
   logic [4:0]                   code_sync;
   logic                         strobe_sync;
   logic                         strobe_prev;
   logic                         key_rise;

   logic [14:0] last_word;
   logic [4:0]  keycode;
   logic        key_pending;
   logic        overflow;

   logic [14:0]      fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [CNT_W-1:0] fifo_count;
   logic             fifo_full;
   logic             fifo_pop;
   logic             fifo_push;
   logic             fifo_drop;
   logic             wr_last;
   logic             clr_key;
   logic             clr_ovf;
   logic [2:0]       count_disp;

   assign sync_last   = async_sync[SYNC_STAGES-1];
   assign ext_sync    = sync_last[59:0];
   assign code_sync   = sync_last[64:60];
   assign strobe_sync = sync_last[65];
   assign key_rise    = strobe_sync & ~strobe_prev;

   assign wr_last = IO_write_en_F && (IO_write_sel == 5'o10);
   assign clr_key = IO_write_en_F && (IO_write_sel == 5'o37) && IO_write_data[0];
   assign clr_ovf = IO_write_en_F && (IO_write_sel == 5'o37) && IO_write_data[1];

   assign fifo_full  = (fifo_count == CNT_W'(FIFO_DEPTH));
   assign dsky_valid = (fifo_count != '0);
   assign fifo_pop   = dsky_valid & dsky_ready;
   assign fifo_push  = wr_last & (~fifo_full | fifo_pop);
   assign fifo_drop  = wr_last & fifo_full & ~fifo_pop;
   assign dsky_data  = dsky_valid ? fifo_mem[rd_ptr] : 15'd0;

   // Multi-stage synchronizer shift chain for all asynchronous inputs
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         async_sync <= '0;
      end else begin
         async_sync <= {async_sync[SYNC_STAGES-2:0], {key_strobe, key_code, ext_in}};
      end
   end

   // Output channel registers and the last-word register loaded by Core writes
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         out_ch11  <= '0;
         out_ch12  <= '0;
         out_ch13  <= '0;
         out_ch14  <= '0;
         last_word <= '0;
      end else if (IO_write_en_F) begin
         case (IO_write_sel)
            5'o10:   last_word <= IO_write_data;
            5'o11:   out_ch11  <= IO_write_data;
            5'o12:   out_ch12  <= IO_write_data;
            5'o13:   out_ch13  <= IO_write_data;
            5'o14:   out_ch14  <= IO_write_data;
            default: ;
         endcase
      end
   end

   // Keyboard capture on a synchronized strobe rise; a new key beats a clear
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         strobe_prev <= 1'b0;
         keycode     <= '0;
         key_pending <= 1'b0;
      end else begin
         strobe_prev <= strobe_sync;
         if (key_rise) begin
            key_pending <= 1'b1;
            keycode     <= code_sync;
         end else if (clr_key) begin
            key_pending <= 1'b0;
         end
      end
   end

   // Sticky overflow flag, set when a display word is dropped
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         overflow <= 1'b0;
      end else if (fifo_drop) begin
         overflow <= 1'b1;
      end else if (clr_ovf) begin
         overflow <= 1'b0;
      end
   end

   // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (fifo_push) wr_ptr <= wr_ptr + 1'b1;
         if (fifo_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({fifo_push, fifo_pop})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: ;
         endcase
      end
   end

   // FIFO storage; contents need no reset since the count gates visibility
   always_ff @(posedge clock) begin
      if (fifo_push) fifo_mem[wr_ptr] <= IO_write_data;
   end

   // Status count field saturates at 7 for deeper queues
   always_comb begin
      count_disp = 3'(fifo_count);
      if (32'(fifo_count) > 32'd7) count_disp = 3'd7;
   end

   // Side-effect-free channel read mux over registered state
   always_comb begin
      IO_read_data = 15'd0;
      case (IO_read_sel)
         5'o10:   IO_read_data = last_word;
         5'o11:   IO_read_data = out_ch11;
         5'o12:   IO_read_data = out_ch12;
         5'o13:   IO_read_data = out_ch13;
         5'o14:   IO_read_data = out_ch14;
         5'o15:   IO_read_data = {10'b0, keycode};
         5'o30:   IO_read_data = ext_sync[14:0];
         5'o31:   IO_read_data = ext_sync[29:15];
         5'o32:   IO_read_data = ext_sync[44:30];
         5'o33:   IO_read_data = ext_sync[59:45];
         5'o37:   IO_read_data = {10'b0, count_disp, overflow, key_pending};
         default: IO_read_data = 15'd0;
      endcase
   end

endmodule

// File: tb/tb_io_channels.sv
// tb_io_channels: directed test-plan scenarios plus randomized traffic,
// checked against a transaction-level model of the channel map.
module tb_io_channels;

   localparam int DEPTH = 4;
   localparam int S     = 2;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic [4:0]  IO_read_sel = '0;
   logic [14:0] IO_read_data;
   logic [4:0]  IO_write_sel = '0;
   logic [14:0] IO_write_data = '0;
   logic        IO_write_en_F = 1'b0;
   logic [59:0] ext_in = '0;
   logic [4:0]  key_code = '0;
   logic        key_strobe = 1'b0;
   logic [14:0] out_ch11, out_ch12, out_ch13, out_ch14;
   logic [14:0] dsky_data;
   logic        dsky_valid;
   logic        dsky_ready = 1'b0;

   int n_checks = 0;
   int n_errors = 0;

   io_channels #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(S)) dut (
      .clock(clock), .reset_n(reset_n),
      .IO_read_sel(IO_read_sel), .IO_read_data(IO_read_data),
      .IO_write_sel(IO_write_sel), .IO_write_data(IO_write_data),
      .IO_write_en_F(IO_write_en_F),
      .ext_in(ext_in), .key_code(key_code), .key_strobe(key_strobe),
      .out_ch11(out_ch11), .out_ch12(out_ch12), .out_ch13(out_ch13), .out_ch14(out_ch14),
      .dsky_data(dsky_data), .dsky_valid(dsky_valid), .dsky_ready(dsky_ready)
   );

   always #5 clock = ~clock;

   // Abstract model state: registers as plain values, FIFO as a queue,
   // and a history of per-edge input samples (index 0 = newest edge).
   logic [14:0] m_ch [4];
   logic [14:0] m_last;
   logic [4:0]  m_keycode;
   logic        m_pending;
   logic        m_overflow;
   logic [14:0] m_fifo [$];
   logic [65:0] hist [$];

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) m_ch[i] = '0;
      m_last = '0; m_keycode = '0; m_pending = 1'b0; m_overflow = 1'b0;
      m_fifo.delete();
      hist.delete();
      for (int i = 0; i < S + 2; i++) hist.push_back('0);
   endtask

   function automatic logic [14:0] exp_read(input logic [4:0] sel);
      int cnt;
      logic [65:0] vis;
      vis = hist[S-1];
      cnt = (m_fifo.size() > 7) ? 7 : m_fifo.size();
      case (sel)
         5'o10: return m_last;
         5'o11, 5'o12, 5'o13, 5'o14: return m_ch[int'(sel) - 9];
         5'o15: return {10'b0, m_keycode};
         5'o30, 5'o31, 5'o32, 5'o33: return vis[15*(int'(sel)-24) +: 15];
         5'o37: return {10'b0, 3'(cnt), m_overflow, m_pending};
         default: return 15'd0;
      endcase
   endfunction

   // Apply the rules for one clock edge using the inputs present before it
   task automatic model_step();
      logic clr_k, clr_o;
      logic [65:0] newer, older;
      if (!reset_n) begin
         model_reset();
         return;
      end
      clr_k = 1'b0; clr_o = 1'b0;
      if (m_fifo.size() > 0 && dsky_ready) void'(m_fifo.pop_front());
      if (IO_write_en_F) begin
         case (IO_write_sel)
            5'o10: begin
               m_last = IO_write_data;
               if (m_fifo.size() < DEPTH) m_fifo.push_back(IO_write_data);
               else m_overflow = 1'b1;
            end
            5'o11, 5'o12, 5'o13, 5'o14: m_ch[int'(IO_write_sel) - 9] = IO_write_data;
            5'o37: begin clr_k = IO_write_data[0]; clr_o = IO_write_data[1]; end
            default: ;
         endcase
      end
      if (clr_o) m_overflow = 1'b0;
      if (clr_k) m_pending = 1'b0;
      hist.push_front({key_strobe, key_code, ext_in});
      void'(hist.pop_back());
      newer = hist[S];
      older = hist[S+1];
      if (newer[65] && !older[65]) begin
         m_pending = 1'b1;
         m_keycode = newer[64:60];
      end
   endtask

   task automatic checkAll(input string tag);
      checkOutput({tag, ".rd"},    IO_read_data, exp_read(IO_read_sel));
      checkOutput({tag, ".ch11"},  out_ch11, m_ch[0]);
      checkOutput({tag, ".ch12"},  out_ch12, m_ch[1]);
      checkOutput({tag, ".ch13"},  out_ch13, m_ch[2]);
      checkOutput({tag, ".ch14"},  out_ch14, m_ch[3]);
      checkOutput({tag, ".valid"}, dsky_valid, m_fifo.size() > 0);
      checkOutput({tag, ".data"},  dsky_data, (m_fifo.size() > 0) ? m_fifo[0] : 15'd0);
   endtask

   task automatic tick(input string tag);
      model_step();
      @(posedge clock);
      #1;
      checkAll(tag);
   endtask

   task automatic applyStimulus(input logic [4:0] rsel, input logic [4:0] wsel,
                                input logic [14:0] wdata, input logic wen, input logic rdy);
      IO_read_sel   = rsel;
      IO_write_sel  = wsel;
      IO_write_data = wdata;
      IO_write_en_F = wen;
      dsky_ready    = rdy;
   endtask

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      model_reset();
      // Reset state and full read sweep
      reset_n = 1'b0;
      tick("rst");
      tick("rst");
      reset_n = 1'b1;
      for (int s = 0; s < 32; s++) begin
         IO_read_sel = 5'(s);
         #1;
         checkOutput("rst_sweep", IO_read_data, 15'd0);
      end
      checkOutput("rst_valid", dsky_valid, 1'b0);
      checkOutput("rst_ch11", out_ch11, 15'd0);

      // Output channel write, no read bypass; read-only channel write ignored
      applyStimulus(5'o12, 5'o12, 15'o12345, 1'b1, 1'b0);
      #1;
      checkOutput("ch12_before", IO_read_data, 15'd0);
      tick("ch12");
      checkOutput("ch12_after", IO_read_data, 15'o12345);
      checkOutput("ch12_port", out_ch12, 15'o12345);
      applyStimulus(5'o15, 5'o15, 15'o777, 1'b1, 1'b0);
      tick("wr015");
      IO_write_en_F = 1'b0;
      #1;
      checkOutput("ro015", IO_read_data, 15'd0);

      // Overflow with driver stalled, then drain
      for (int i = 1; i <= 5; i++) begin
         applyStimulus(5'o37, 5'o10, 15'(i), 1'b1, 1'b0);
         tick("fill");
      end
      IO_write_en_F = 1'b0;
      #1;
      checkOutput("ovf_status", IO_read_data, 15'd18);
      IO_read_sel = 5'o10;
      #1;
      checkOutput("ovf_last", IO_read_data, 15'o5);
      checkOutput("ovf_head", dsky_data, 15'o1);
      dsky_ready = 1'b1;
      for (int i = 2; i <= 5; i++) begin
         tick("drain");
         checkOutput("drain_head", dsky_data, (i <= 4) ? 15'(i) : 15'd0);
      end
      checkOutput("drain_valid", dsky_valid, 1'b0);

      // Clear overflow, refill, then simultaneous push and pop when full
      applyStimulus(5'o37, 5'o37, 15'd2, 1'b1, 1'b0);
      tick("clr_ovf");
      for (int i = 0; i < 4; i++) begin
         applyStimulus(5'o37, 5'o10, 15'o11 + 15'(i), 1'b1, 1'b0);
         tick("refill");
      end
      applyStimulus(5'o37, 5'o10, 15'o15, 1'b1, 1'b1);
      tick("pushpop");
      checkOutput("pushpop_status", IO_read_data, 15'd16);
      checkOutput("pushpop_head", dsky_data, 15'o12);
      applyStimulus(5'o37, 5'o0, 15'd0, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) tick("drain2");

      // Keyboard capture latency and single capture on a held strobe
      applyStimulus(5'o15, 5'o0, 15'd0, 1'b0, 1'b0);
      key_code   = 5'd19;
      key_strobe = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick("key");
         checkOutput("key_code015", IO_read_data, (i >= 2) ? 15'd19 : 15'd0);
      end
      applyStimulus(5'o37, 5'o37, 15'd1, 1'b1, 1'b0);
      tick("key_clr");
      IO_write_en_F = 1'b0;
      for (int i = 0; i < 3; i++) tick("key_hold");
      checkOutput("key_once", IO_read_data, 15'd0);
      key_strobe = 1'b0;
      for (int i = 0; i < 4; i++) tick("key_low");
      key_strobe = 1'b1;
      tick("key_k");
      tick("key_k1");
      applyStimulus(5'o37, 5'o37, 15'd1, 1'b1, 1'b0);
      tick("key_setwins");
      IO_write_en_F = 1'b0;
      #1;
      checkOutput("key_setwins", IO_read_data, 15'd1);
      key_strobe = 1'b0;
      for (int i = 0; i < 3; i++) tick("key_rel");

      // Discrete input with a reset pulse mid-pattern; queued words discarded
      applyStimulus(5'o10, 5'o10, 15'o4321, 1'b1, 1'b0);
      tick("prequeue");
      IO_write_en_F = 1'b0;
      IO_read_sel = 5'o31;
      ext_in = 60'(15'o77777) << 15;
      tick("ext");
      reset_n = 1'b0;
      model_reset();
      #1;
      checkAll("ext_rst_async");
      for (int i = 0; i < 3; i++) begin
         tick("ext_rst");
         checkOutput("ext_in_rst", IO_read_data, 15'd0);
      end
      reset_n = 1'b1;
      tick("ext_rel1");
      checkOutput("ext_rel1", IO_read_data, 15'd0);
      tick("ext_rel2");
      checkOutput("ext_rel2", IO_read_data, 15'o77777);

      // Randomized traffic against the model
      for (int c = 0; c < 600; c++) begin
         logic [4:0] wsel;
         case ($urandom_range(0, 7))
            0, 1:    wsel = 5'o10;
            2:       wsel = 5'o11 + 5'($urandom_range(0, 3));
            3:       wsel = 5'o37;
            4:       wsel = 5'o15;
            5:       wsel = 5'o30 + 5'($urandom_range(0, 3));
            default: wsel = 5'($urandom_range(0, 31));
         endcase
         applyStimulus(5'($urandom_range(0, 31)), wsel, 15'($urandom),
                       1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0));
         if ($urandom_range(0, 5) == 0) ext_in = {$urandom, $urandom} & 60'hFFF_FFFF_FFFF_FFFF;
         if ($urandom_range(0, 7) == 0) begin
            if (!key_strobe) key_code = 5'($urandom);
            key_strobe = ~key_strobe;
         end
         tick("rand");
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/io_channels.md
# io_channels

Responder side of the Core's I/O channel bus. It holds the output channel registers that the Core writes in writeback. It returns channel contents to the Core's decode-stage read port, and synchronizes external inputs into input channels. It also latches DSKY keycodes and queues DSKY display words in a small FIFO with a valid/ready handshake toward the display driver. It sits between Core (IO_* ports) and the board-level DSKY/discrete I/O.

## Interface
- FIFO_DEPTH, 4, DSKY output queue depth; power of two, ≥2
- SYNC_STAGES, 2, flop stages on every asynchronous input; ≥2
- clock  in  1  system clock, all state on posedge
- reset_n  in  1  asynchronous, active-low reset
- IO_read_sel  in  5  channel the Core reads (combinational read)
- IO_read_data  out  15  contents of IO_read_sel channel
- IO_write_sel  in  5  channel the Core writes
- IO_write_data  in  15  write data
- IO_write_en_F  in  1  write strobe, sampled at posedge
- ext_in  in  60  async discretes; [15c+14:15c] feeds channel 030+c, c=0..3
- key_code  in  5  DSKY keycode, stable while key_strobe high
- key_strobe  in  1  async key-press level
- out_ch11, out_ch12, out_ch13, out_ch14  out  15 each  output channel registers
- dsky_data  out  15  FIFO head word, 0 when empty
- dsky_valid  out  1  FIFO non-empty
- dsky_ready  in  1  driver accepts head at posedge when valid & ready

## Operation
- Channel map (octal), reads:
  - 010: last word written.
  - 011–014: the register.
  - 015: {10'b0, latched keycode}.
  - 030–033: synchronized ext_in slice.
  - 037: status {10'b0, fifo_count[2:0], overflow, key_pending}. fifo_count saturates display at 7.
  - All others read 0.
- Writes, accepted on posedge when IO_write_en_F=1:
  - 011–014: load the register.
  - 010: load the last-word register and push into the FIFO.
  - 037: bit0=1 clears key_pending, bit1=1 clears overflow.
  - Writes to any other channel, including read-only 015/030–033, are ignored.
- Reads are side-effect free. IO_read_data is purely combinational from registered state; a write and a read of the same channel in one cycle returns the old value (no bypass).
- Keyboard path:
  - key_strobe passes through SYNC_STAGES flops, then an edge-detect flop.
  - A rising edge on the synchronized strobe captures key_code (synchronized in parallel) and sets key_pending.
  - A set and a clear in the same cycle: set wins.
- FIFO behaviour:
  - Push when count<FIFO_DEPTH, or when full with a pop in the same cycle. Both happen, count unchanged.
  - Push when full without a pop: the word is dropped, overflow is set (sticky); the last-word register still updates.
  - A pop when empty is impossible (valid=0).
  - Pointers wrap modulo FIFO_DEPTH.
- Reset (async assert, sync-released by system):
  - All channel registers, synchronizers, keycode, key_pending, overflow and FIFO pointers/count go to 0.
  - Outputs after reset: IO_read_data=0 for every sel, out_ch11–14=0, dsky_data=0, dsky_valid=0.
  - Reset mid-queue discards all queued words.

## Timing
- Output channel write: visible on out_chNN and IO_read_data one posedge after the write edge (i.e. right after the edge where IO_write_en_F was sampled).
- ext_in change sampled at edge k: visible on channel 030–033 after edge k+SYNC_STAGES-1 (k+1 for default).
- key_strobe rise sampled at edge k: key_pending=1 and keycode valid after edge k+SYNC_STAGES (k+2 default). A held strobe produces exactly one capture.
- Write to 010 at edge k into an empty FIFO: dsky_valid=1, dsky_data=word after edge k.
- A pop at edge k exposes the next entry after edge k. Throughput is one word per cycle with dsky_ready held high.
- Status count and overflow update on the same edge as the push/pop that changes them.

## Test plan
- Reset, then sweep IO_read_sel 0–31 -> IO_read_data=0 everywhere, dsky_valid=0, out_ch11–14=0.
- Write 0o12345 to 012 at edge k, reading 012 the same cycle -> read returns 0 before edge k, 0o12345 after it; out_ch12=0o12345; writing 015 leaves its value unchanged.
- Hold dsky_ready=0 and write 0o1,0o2,0o3,0o4,0o5 to 010 -> count=4, status bit1 set, last-word=0o5. Then raise ready -> drains 0o1..0o4 on consecutive cycles, valid drops after the 4th.
- FIFO full, with a push and pop (ready=1) on the same edge -> count stays 4, no overflow, head advances by one entry.
- key_code=5'd19, key_strobe rise sampled at edge k and held 10 cycles -> channel 015=19 and key_pending=1 after edge k+2, one capture only. Write 037 with bit0=1 on the same edge as a new strobe edge -> key_pending stays 1.
- ext_in slice 031=0o77777 applied, with reset_n pulsed low mid-pattern -> 0 throughout reset, 0o77777 two edges after release plus sampling.
